// File: rtl/nvme_host_cmd_issuer_if.sv
`default_nettype none
// ============================================================================
// Module      : nvme_host_cmd_issuer_if
// Description : This interface bundles the host request channel, the PCIe
//               command and response beats, and the completion channel of
//               the NVMe host command issuer.
//               The slave modport is the issuer's own view. The master
//               modport is the environment's view: host logic plus the
//               controller.
//               With NVME_HOST_CMD_STATS_EN defined, the interface also
//               carries the statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
interface nvme_host_cmd_issuer_if;
    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic [127:0] pcie_cmd_data;
    logic         pcie_cmd_valid;
    logic [127:0] pcie_rsp_data;
    logic         pcie_rsp_valid;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_error;
    logic         busy;
`ifdef NVME_HOST_CMD_STATS_EN
    logic [15:0]  stat_cmd_count;
    logic [15:0]  stat_timeout_count;
`endif

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, pcie_rsp_data, pcie_rsp_valid,
        output req_ready, pcie_cmd_data, pcie_cmd_valid, rsp_valid, rsp_rdata, rsp_error, busy
`ifdef NVME_HOST_CMD_STATS_EN
        , output stat_cmd_count, stat_timeout_count
`endif
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, pcie_rsp_data, pcie_rsp_valid,
        input  req_ready, pcie_cmd_data, pcie_cmd_valid, rsp_valid, rsp_rdata, rsp_error, busy
`ifdef NVME_HOST_CMD_STATS_EN
        , input stat_cmd_count, stat_timeout_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/nvme_host_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : nvme_host_cmd_issuer
// Description : This block is a single-outstanding NVMe host initiator.
//               - It formats each accepted request into one 128-bit command
//                 beat.
//               - For reads, it waits for the response beat or for a
//                 timeout.
//               - It then reports one completion pulse.
//               Optional macro NVME_HOST_CMD_STATS_EN adds saturating counters
//               for issued commands and read timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module nvme_host_cmd_issuer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    nvme_host_cmd_issuer_if.slave  bus
);

    localparam logic [7:0]  c_opc_read     = 8'h01;
    localparam logic [7:0]  c_opc_write    = 8'h02;
    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t         r_state;
    logic           r_write;
    logic [15:0]    r_wait_cnt;
    logic           r_req_ready;
    logic           r_busy;
    logic           r_cmd_valid;
    logic [127:0]   r_cmd_data;
    logic           r_rsp_valid;
    logic [31:0]    r_rsp_rdata;
    logic           r_rsp_error;

    logic           w_timeout;
    logic           w_unused_rsp_bits;

    // Only the read-data lane of the response beat carries meaning here.
    assign w_unused_rsp_bits = ^bus.pcie_rsp_data[95:0];

    // Final WAIT cycle with no response; a response in that cycle takes priority.
    assign w_timeout = (r_state == ST_WAIT) && !bus.pcie_rsp_valid &&
                       (r_wait_cnt == c_timeout_last);

    // Request FSM; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_wait_cnt  <= 16'd0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_write     <= bus.req_write;
                        r_cmd_valid <= 1'b1;
                        r_cmd_data  <= {bus.req_write ? bus.req_wdata : 32'h0,
                                        32'h0,
                                        bus.req_addr,
                                        24'h0,
                                        bus.req_write ? c_opc_write : c_opc_read};
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cmd_valid <= 1'b0;
                    r_cmd_data  <= '0;
                    if (r_write) begin
                        // Writes are posted: complete without a response.
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_error <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (bus.pcie_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= bus.pcie_rsp_data[127:96];
                        r_rsp_error <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= 16'd0;
                        r_state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.pcie_rsp_valid) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= bus.pcie_rsp_data[127:96];
                        r_rsp_error <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                        r_rsp_error <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wait_cnt  <= r_wait_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_rsp_error <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.busy           = r_busy;
    assign bus.pcie_cmd_valid = r_cmd_valid;
    assign bus.pcie_cmd_data  = r_cmd_data;
    assign bus.rsp_valid      = r_rsp_valid;
    assign bus.rsp_rdata      = r_rsp_rdata;
    assign bus.rsp_error      = r_rsp_error;

`ifdef NVME_HOST_CMD_STATS_EN
    logic [15:0] r_stat_cmd;
    logic [15:0] r_stat_timeout;

    // Saturating counts of issued command beats and read timeouts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_cmd     <= 16'd0;
            r_stat_timeout <= 16'd0;
        end else begin
            if ((r_state == ST_ISSUE) && (r_stat_cmd != 16'hFFFF)) begin
                r_stat_cmd <= r_stat_cmd + 16'd1;
            end
            if (w_timeout && (r_stat_timeout != 16'hFFFF)) begin
                r_stat_timeout <= r_stat_timeout + 16'd1;
            end
        end
    end

    assign bus.stat_cmd_count     = r_stat_cmd;
    assign bus.stat_timeout_count = r_stat_timeout;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nvme_host_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nvme_host_cmd_issuer
// Description : This is a scoreboard testbench for nvme_host_cmd_issuer.
//               - The driver issues directed and random requests, and plays
//                 the controller's response timing.
//               - It pushes the expected command beat and completion for
//                 each request.
//               - A monitor compares every observed beat against those
//                 expectations.
//               The bench follows NVME_HOST_CMD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nvme_host_cmd_issuer;

    localparam int T = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nvme_host_cmd_issuer_if bus();

    nvme_host_cmd_issuer #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { logic [127:0] data; int at; } cmd_exp_t;
    typedef struct { logic [31:0] rdata; logic err; int at; } rsp_exp_t;
    cmd_exp_t cmd_q[$];
    rsp_exp_t rsp_q[$];
    cmd_exp_t ce;
    rsp_exp_t re;
    int last_acc = -10;
    int m_cmds   = 0;
    int m_touts  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] fmt(input bit w, input logic [31:0] a, input logic [31:0] wd);
        return {w ? wd : 32'h0, 32'h0, a, 24'h0, w ? 8'h02 : 8'h01};
    endfunction

    // Monitor: checks handshake, command beats and completions each cycle.
    always @(negedge clk) begin
        if (rst) begin
            cmd_q.delete();
            rsp_q.delete();
            last_acc = -10;
        end else begin
            if (cyc == last_acc + 1 || cyc == last_acc + 2) begin
                chk("ready_low_after_accept", 128'(bus.req_ready), 128'd0);
                chk("busy_after_accept", 128'(bus.busy), 128'd1);
            end
            if (bus.req_valid && bus.req_ready) last_acc = cyc;

            if (bus.pcie_cmd_valid) begin
                if (cmd_q.size() == 0) begin
                    chk("cmd_unexpected", 128'(bus.pcie_cmd_valid), 128'd0);
                end else begin
                    ce = cmd_q.pop_front();
                    chk("cmd_cycle", 128'(cyc), 128'(ce.at));
                    chk("cmd_data", bus.pcie_cmd_data, ce.data);
                end
            end else begin
                chk("cmd_data_zero_when_idle", bus.pcie_cmd_data, 128'd0);
                if (cmd_q.size() > 0 && cmd_q[0].at < cyc) begin
                    chk("cmd_missing", 128'(bus.pcie_cmd_valid), 128'd1);
                    void'(cmd_q.pop_front());
                end
            end

            if (bus.rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 128'(bus.rsp_valid), 128'd0);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_cycle", 128'(cyc), 128'(re.at));
                    chk("rsp_rdata", 128'(bus.rsp_rdata), 128'(re.rdata));
                    chk("rsp_error", 128'(bus.rsp_error), 128'(re.err));
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].at < cyc) begin
                chk("rsp_missing", 128'(bus.rsp_valid), 128'd1);
                void'(rsp_q.pop_front());
            end
        end
    end

    // One request; d = 0..T is the WAIT cycle carrying the response (0 = ISSUE), d > T = none.
    task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] wd,
                         input int d, input logic [31:0] rd, input bit stray);
        int n;
        int acc;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus.req_ready) break;
        end
        if (n == 50) begin
            chk("ready_wait_timeout", 128'(bus.req_ready), 128'd1);
            bus.req_valid = 1'b0;
            return;
        end
        acc = cyc;
        cmd_q.push_back('{data: fmt(w, a, wd), at: acc + 1});
        m_cmds++;
        if (w)           rsp_q.push_back('{rdata: 32'h0, err: 1'b0, at: acc + 2});
        else if (d <= T) rsp_q.push_back('{rdata: rd, err: 1'b0, at: acc + 2 + d});
        else begin
            rsp_q.push_back('{rdata: 32'h0, err: 1'b1, at: acc + 2 + T});
            m_touts++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        if (w) begin
            if (stray) begin
                bus.pcie_rsp_valid = 1'b1;
                bus.pcie_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); #1;
                bus.pcie_rsp_valid = 1'b0;
            end
        end else if (d <= T) begin
            repeat (d) begin @(posedge clk); #1; end
            bus.pcie_rsp_valid = 1'b1;
            bus.pcie_rsp_data  = {rd, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            bus.pcie_rsp_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 200; n++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && cmd_q.size() == 0) break;
        end
        if (n == 200) chk("drain_timeout", 128'(rsp_q.size()), 128'd0);
        @(posedge clk); #1;
    endtask

    task automatic idle_gap(input int n, input bit stray);
        drain();
        repeat (n) begin
            bus.pcie_rsp_valid = stray ? 1'($urandom % 2) : 1'b0;
            bus.pcie_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        bus.pcie_rsp_valid = 1'b0;
    endtask

    task automatic chk_reset_values();
        chk("rst_req_ready", 128'(bus.req_ready), 128'd1);
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_cmd_valid", 128'(bus.pcie_cmd_valid), 128'd0);
        chk("rst_cmd_data", bus.pcie_cmd_data, 128'd0);
        chk("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
        chk("rst_rsp_rdata", 128'(bus.rsp_rdata), 128'd0);
        chk("rst_rsp_error", 128'(bus.rsp_error), 128'd0);
`ifdef NVME_HOST_CMD_STATS_EN
        chk("rst_stat_cmd", 128'(bus.stat_cmd_count), 128'd0);
        chk("rst_stat_timeout", 128'(bus.stat_timeout_count), 128'd0);
`endif
    endtask

    // Watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    // Stimulus
    initial begin
        bit w;
        int d;
        bus.req_valid      = 1'b0;
        bus.req_write      = 1'b0;
        bus.req_addr       = 32'h0;
        bus.req_wdata      = 32'h0;
        bus.pcie_rsp_valid = 1'b0;
        bus.pcie_rsp_data  = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_values();
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed cases
        issue(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
        idle_gap(2, 1'b0);
        issue(1'b0, 32'h0000_0020, 32'h0, 0, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 32'h0000_0040, 32'h0, 5, 32'h1234_5678, 1'b0);
        issue(1'b0, 32'h0000_0044, 32'h0, T + 1, 32'h0, 1'b0);
        issue(1'b0, 32'h0000_0048, 32'h0, T, 32'hA5A5_5A5A, 1'b0);
        issue(1'b1, 32'h0000_2000, 32'h1111_2222, 0, 32'h0, 1'b0);
        issue(1'b1, 32'h0000_2004, 32'h3333_4444, 0, 32'h0, 1'b0);
        issue(1'b1, 32'h0000_2008, 32'h5555_6666, 0, 32'h0, 1'b1);
        idle_gap(6, 1'b1);

        // Random traffic
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom % 2);
            d = $urandom_range(0, T + 1);
            issue(w, $urandom, $urandom, d, $urandom, 1'($urandom % 4 == 0));
            if ($urandom % 5 == 0) idle_gap($urandom_range(1, 4), 1'b1);
        end

        drain();
`ifdef NVME_HOST_CMD_STATS_EN
        chk("stat_cmd_count", 128'(bus.stat_cmd_count), 128'(m_cmds));
        chk("stat_timeout_count", 128'(bus.stat_timeout_count), 128'(m_touts));
`endif

        // Reset while a read waits for its response
        issue(1'b0, 32'h0000_0080, 32'h0, T + 1, 32'h0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        m_cmds  = 0;
        m_touts = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values();
        @(posedge clk); #1;
        bus.pcie_rsp_valid = 1'b1;
        bus.pcie_rsp_data  = {32'hBAD0_BAD0, 96'h0};
        repeat (2) begin @(posedge clk); #1; end
        bus.pcie_rsp_valid = 1'b0;
        repeat (T + 4) begin @(posedge clk); #1; end
        issue(1'b1, 32'h0000_3000, 32'h7777_8888, 0, 32'h0, 1'b0);
        drain();
`ifdef NVME_HOST_CMD_STATS_EN
        chk("stat_cmd_after_reset", 128'(bus.stat_cmd_count), 128'(m_cmds));
        chk("stat_timeout_after_reset", 128'(bus.stat_timeout_count), 128'(m_touts));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
